mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port memory between the datapath's instruction-fetch (I) and data (D) ports.
//  Sits between datapath imem_*/dmem_* and the unified memory model; one transaction outstanding.
//  Sequences request -> issue -> response and routes read data back to the owning requester.
//  Watchdog on memory response; sticky error feeds the core error line.
// PARAMETERS
//  XLEN          32   data/address width (from constants.vh)
//  RESP_TIMEOUT  255  max cycles in ISSUE+WAIT before error; 8-bit counter, legal 1..255
// PORTS
//  clk         in   1     sole clock, rising edge
//  reset_n     in   1     asynchronous, active-low reset
//  i_req       in   1     fetch read request
//  i_addr      in   XLEN  fetch address
//  i_gnt       out  1     1-cycle pulse: I request accepted
//  i_rvalid    out  1     1-cycle pulse: i_rdata valid
//  i_rdata     out  XLEN  fetch data
//  d_req       in   1     data request
//  d_we        in   1     1 = store, 0 = load
//  d_addr      in   XLEN  data address
//  d_wdata     in   XLEN  store data
//  d_gnt       out  1     1-cycle pulse: D request accepted
//  d_rvalid    out  1     1-cycle pulse: load data valid, or store complete
//  d_rdata     out  XLEN  load data
//  mem_req     out  1     request to memory, held until mem_gnt
//  mem_we      out  1     write enable to memory
//  mem_addr    out  XLEN  memory address (registered)
//  mem_wdata   out  XLEN  memory write data (registered)
//  mem_gnt     in   1     memory accepts request this cycle
//  mem_rvalid  in   1     memory read data valid this cycle
//  mem_rdata   in   XLEN  memory read data
//  error       out  1     sticky response-timeout flag
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; all outputs 0; owner=I; last_winner=I; counter=0.
//  - FSM states: IDLE, ISSUE, WAIT, ERR.
//  - IDLE: if any req, pick winner; x_gnt=1 combinationally this cycle; latch owner/we/addr/wdata; ->ISSUE.
//    The requester may drop or change req after x_gnt.
//  - ISSUE: mem_req=1 with latched payload stable; on mem_gnt: store -> d_rvalid=1 next cycle, ->IDLE;
//    load -> WAIT.
//  - WAIT: on mem_rvalid, owner's x_rvalid=1 and x_rdata=mem_rdata in the same cycle; ->IDLE.
//    Non-owner rvalid stays 0 and its rdata holds.
//  - Min load latency: accept T0, mem_gnt T1, response T2. No new grant in the cycle leaving ISSUE/WAIT.
//  - Counter clears on entering ISSUE and increments each cycle in ISSUE/WAIT.
//    When counter==RESP_TIMEOUT and no completion that cycle: error=1, ->ERR.
//  - ERR: terminal until reset; no grants, mem_req=0, error held 1.
//  - mem_gnt outside ISSUE and mem_rvalid outside WAIT are ignored.
//  - Completion in the same cycle the counter hits the limit wins: no error.
//  - Simultaneous i_req and d_req in IDLE: arbitration policy below; the loser's gnt stays 0.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin. last_winner updates on each grant; when both request,
//    the non-last requester wins. First contention after reset goes to D.
//  MEM_ARB_RR_EN undefined: fixed priority, D always beats I; last_winner logic is not built.
// STRUCTURE
//  - constants.vh holds ARB_ST_IDLE/ISSUE/WAIT/ERR (2-bit), ARB_OWNER_I/ARB_OWNER_D, ARB_CNT_LEN=8.
//  - One sub-module, arb_timer: clear/enable/limit inputs, 8-bit count, expired output.
//  - FSM, payload registers and response routing stay in mem_arbiter.
// TESTING
//  1 Reset: drive reset_n=0 mid-WAIT -> all outputs 0 immediately; after release, i_req grants at T0.
//  2 Single load: d_req, d_addr=0x204, mem_gnt T1, mem_rvalid T2 with rdata=0xDEADBEEF
//    -> d_gnt@T0, mem_addr=0x204, d_rvalid@T2 with d_rdata=0xDEADBEEF; i_rvalid=0.
//  3 Store: d_we=1, d_wdata=0x55 -> mem_we=1, mem_wdata=0x55 until mem_gnt; d_rvalid 1 cycle later.
//  4 Contention: i_req and d_req held high for 4 transactions
//    -> fixed: D,D,D,D; RR: D,I,D,I grant order.
//  5 Stall: mem_gnt held 0 for 3 cycles -> mem_req and payload stable, no second grant.
//  6 Timeout: RESP_TIMEOUT=4, no mem_rvalid -> error=1 after 4 cycles in ISSUE/WAIT;
//    later reqs get no gnt; a late mem_rvalid is ignored.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_ST_IDLE  = 2'd0,
        ARB_ST_ISSUE = 2'd1,
        ARB_ST_WAIT  = 2'd2,
        ARB_ST_ERR   = 2'd3
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_I = 1'b0,
        ARB_OWNER_D = 1'b1
    } arb_owner_e;

    localparam int ARB_CNT_LEN = 8;

endpackage

// File: rtl/arb_timer.sv
// Response watchdog: 8-bit cycle counter, cleared on issue, compared against a limit.
module arb_timer
    import mem_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [ARB_CNT_LEN-1:0] limit,
    output logic                   expired
);

    logic [ARB_CNT_LEN-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == limit);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port memory, one transaction
// outstanding. Define MEM_ARB_RR_EN for round-robin; otherwise D has fixed priority over I.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RESP_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            error
);

    localparam logic [ARB_CNT_LEN-1:0] TIMEOUT_LIMIT = ARB_CNT_LEN'(RESP_TIMEOUT);

    arb_state_e      state_q, state_d;
    arb_owner_e      owner_q, winner;
    logic            we_q;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [XLEN-1:0] i_rdata_q, d_rdata_q;
    logic            store_done_q;
    logic            grant, timer_clear, timer_en, timer_expired, resp;

`ifdef MEM_ARB_RR_EN
    arb_owner_e last_winner_q;

    always_comb begin
        if (i_req && d_req) begin
            winner = (last_winner_q == ARB_OWNER_D) ? ARB_OWNER_I : ARB_OWNER_D;
        end else begin
            winner = d_req ? ARB_OWNER_D : ARB_OWNER_I;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_winner_q <= ARB_OWNER_I;
        end else if (grant) begin
            last_winner_q <= winner;
        end
    end
`else
    assign winner = d_req ? ARB_OWNER_D : ARB_OWNER_I;
`endif

    assign timer_en = (state_q == ARB_ST_ISSUE) || (state_q == ARB_ST_WAIT);

    arb_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .limit   (TIMEOUT_LIMIT),
        .expired (timer_expired)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        timer_clear = 1'b0;
        unique case (state_q)
            ARB_ST_IDLE: begin
                if (i_req || d_req) begin
                    grant       = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = ARB_ST_ISSUE;
                end
            end
            ARB_ST_ISSUE: begin
                if (mem_gnt)            state_d = we_q ? ARB_ST_IDLE : ARB_ST_WAIT;
                else if (timer_expired) state_d = ARB_ST_ERR;
            end
            ARB_ST_WAIT: begin
                if (mem_rvalid)         state_d = ARB_ST_IDLE;
                else if (timer_expired) state_d = ARB_ST_ERR;
            end
            ARB_ST_ERR: state_d = ARB_ST_ERR;
            default:    state_d = ARB_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_ST_IDLE;
            owner_q      <= ARB_OWNER_I;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            store_done_q <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            store_done_q <= (state_q == ARB_ST_ISSUE) && mem_gnt && we_q;
            if (grant) begin
                owner_q <= winner;
                we_q    <= (winner == ARB_OWNER_D) && d_we;
                addr_q  <= (winner == ARB_OWNER_D) ? d_addr : i_addr;
                wdata_q <= (winner == ARB_OWNER_D) ? d_wdata : '0;
            end
            if (resp && (owner_q == ARB_OWNER_I)) i_rdata_q <= mem_rdata;
            if (resp && (owner_q == ARB_OWNER_D)) d_rdata_q <= mem_rdata;
        end
    end

    // Read data flows through in the response cycle; the non-owner keeps its last value.
    assign resp      = (state_q == ARB_ST_WAIT) && mem_rvalid;
    assign i_gnt     = grant && (winner == ARB_OWNER_I);
    assign d_gnt     = grant && (winner == ARB_OWNER_D);
    assign i_rvalid  = resp && (owner_q == ARB_OWNER_I);
    assign d_rvalid  = (resp && (owner_q == ARB_OWNER_D)) || store_done_q;
    assign i_rdata   = (resp && (owner_q == ARB_OWNER_I)) ? mem_rdata : i_rdata_q;
    assign d_rdata   = (resp && (owner_q == ARB_OWNER_D)) ? mem_rdata : d_rdata_q;
    assign mem_req   = (state_q == ARB_ST_ISSUE);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign error     = (state_q == ARB_ST_ERR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed and random transactions against a
// transaction-level model (winner rule, word memory, held read data).
module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam int TMO  = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [XLEN-1:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic            mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;
    logic            i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we, error;
    logic [XLEN-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    mem_arbiter #(.XLEN(XLEN), .RESP_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          last_d  = 1'b0;
    logic [31:0] mem_model [16];
    logic [31:0] held_i = '0, held_d = '0;

    task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Winner rule: lone requester wins; on contention D wins (fixed) or the non-last one (RR).
    function automatic bit pick_d(input bit ir, input bit dr);
        if (ir && dr) return RR ? !last_d : 1'b1;
        return dr;
    endfunction

    // One full transaction starting at an IDLE cycle (called at posedge+1).
    task automatic txn(input string tag, input bit ir, input bit dr, input bit we,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                       input int gdly, input int rdly, input bit hold);
        bit          win_d, store;
        logic [31:0] a, rd;
        i_req = ir; d_req = dr; d_we = we; i_addr = ia; d_addr = da; d_wdata = wd;
        win_d = pick_d(ir, dr);
        last_d = win_d;
        store = win_d && we;
        a = win_d ? da : ia;
        sample();
        check_b({tag, ".i_gnt"}, i_gnt, !win_d);
        check_b({tag, ".d_gnt"}, d_gnt, win_d);
        step();
        if (!hold) begin
            i_req = 1'b0; d_req = 1'b0;
            i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
        end
        for (int k = 0; k < gdly; k++) begin
            if (!hold) begin i_req = 1'($urandom); d_req = 1'($urandom); end
            sample();
            check_b({tag, ".stall_req"}, mem_req, 1'b1);
            check_w({tag, ".stall_addr"}, mem_addr, a);
            check_b({tag, ".stall_we"}, mem_we, store);
            if (store) check_w({tag, ".stall_wdata"}, mem_wdata, wd);
            check_b({tag, ".stall_nognt"}, i_gnt | d_gnt, 1'b0);
            step();
        end
        if (!hold) begin i_req = 1'b0; d_req = 1'b0; end
        mem_gnt = 1'b1;
        sample();
        check_b({tag, ".mem_req"}, mem_req, 1'b1);
        check_w({tag, ".mem_addr"}, mem_addr, a);
        check_b({tag, ".mem_we"}, mem_we, store);
        if (store) check_w({tag, ".mem_wdata"}, mem_wdata, wd);
        step();
        mem_gnt = 1'b0;
        if (store) begin
            mem_model[a[5:2]] = wd;
            sample();
            check_b({tag, ".st_d_rvalid"}, d_rvalid, 1'b1);
            check_b({tag, ".st_i_rvalid"}, i_rvalid, 1'b0);
            check_b({tag, ".st_error"}, error, 1'b0);
            step();
        end else begin
            for (int k = 0; k < rdly; k++) begin
                if (!hold) begin i_req = 1'($urandom); d_req = 1'($urandom); end
                sample();
                check_b({tag, ".wait_rvalid"}, i_rvalid | d_rvalid, 1'b0);
                check_b({tag, ".wait_memreq"}, mem_req, 1'b0);
                check_b({tag, ".wait_nognt"}, i_gnt | d_gnt, 1'b0);
                step();
            end
            if (!hold) begin i_req = 1'b0; d_req = 1'b0; end
            rd = mem_model[a[5:2]];
            mem_rvalid = 1'b1;
            mem_rdata = rd;
            sample();
            if (win_d) begin
                check_b({tag, ".d_rvalid"}, d_rvalid, 1'b1);
                check_w({tag, ".d_rdata"}, d_rdata, rd);
                check_b({tag, ".i_rvalid"}, i_rvalid, 1'b0);
                check_w({tag, ".i_rdata_hold"}, i_rdata, held_i);
                held_d = rd;
            end else begin
                check_b({tag, ".i_rvalid"}, i_rvalid, 1'b1);
                check_w({tag, ".i_rdata"}, i_rdata, rd);
                check_b({tag, ".d_rvalid"}, d_rvalid, 1'b0);
                check_w({tag, ".d_rdata_hold"}, d_rdata, held_d);
                held_i = rd;
            end
            check_b({tag, ".error"}, error, 1'b0);
            step();
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem_model[k] = $urandom;
        mem_model[1] = 32'hDEAD_BEEF;

        // Reset values
        #2;
        check_b("rst.mem_req", mem_req, 1'b0);
        check_b("rst.gnts", i_gnt | d_gnt, 1'b0);
        check_b("rst.error", error, 1'b0);
        check_w("rst.mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Single load from D
        txn("load", 1'b0, 1'b1, 1'b0, 32'h0, 32'h204, 32'h0, 0, 0, 1'b0);
        // Store with a 2-cycle memory stall, then read it back
        txn("store", 1'b0, 1'b1, 1'b1, 32'h0, 32'h208, 32'h55, 2, 0, 1'b0);
        txn("st_rd", 1'b1, 1'b0, 1'b0, 32'h208, 32'h0, 32'h0, 0, 1, 1'b0);
        // Grant stall of 3 cycles: completion lands exactly when the counter reaches the limit
        txn("stall", 1'b0, 1'b1, 1'b0, 32'h0, 32'h204, 32'h0, 3, 0, 1'b0);
        sample();
        check_b("stall.no_error", error, 1'b0);
        step();

        // Random traffic
        for (int n = 0; n < 24; n++) begin
            bit ir, dr;
            int g;
            ir = 1'($urandom);
            dr = 1'($urandom);
            if (!ir && !dr) dr = 1'b1;
            g = int'($urandom_range(0, 2));
            txn("rand", ir, dr, 1'($urandom),
                {26'h0, 4'($urandom), 2'b00}, {26'h0, 4'($urandom), 2'b00}, $urandom,
                g, int'($urandom_range(0, 3 - g)), 1'b0);
        end

        // Async reset in the middle of WAIT
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        sample();
        check_b("rstw.d_gnt", d_gnt, 1'b1);
        step();
        d_req = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        reset_n = 1'b0;
        #1;
        check_b("rstw.mem_req", mem_req, 1'b0);
        check_w("rstw.mem_addr", mem_addr, 32'h0);
        check_w("rstw.d_rdata", d_rdata, 32'h0);
        check_w("rstw.i_rdata", i_rdata, 32'h0);
        check_b("rstw.rvalid", i_rvalid | d_rvalid, 1'b0);
        check_b("rstw.error", error, 1'b0);
        last_d = 1'b0; held_i = '0; held_d = '0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        txn("post_rst", 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 0, 0, 1'b0);

        // Contention: both held high across four loads
        for (int n = 0; n < 4; n++) begin
            txn("contend", 1'b1, 1'b1, 1'b0, 32'h4 * n, 32'h30 + 32'h4 * n, 32'h0, 0, 0, n != 3);
        end

        // Timeout: memory grants but never responds
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3C;
        sample();
        check_b("tmo.d_gnt", d_gnt, 1'b1);
        step();
        d_req = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            sample();
            check_b("tmo.early_error", error, 1'b0);
            step();
        end
        step();
        sample();
        check_b("tmo.error", error, 1'b1);
        check_b("tmo.mem_req", mem_req, 1'b0);
        step();
        mem_rvalid = 1'b1;
        mem_rdata = 32'hA5A5_0001;
        sample();
        check_b("tmo.late_rvalid", d_rvalid | i_rvalid, 1'b0);
        check_w("tmo.d_rdata_hold", d_rdata, held_d);
        step();
        mem_rvalid = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            check_b("tmo.no_gnt", i_gnt | d_gnt, 1'b0);
            check_b("tmo.no_req", mem_req, 1'b0);
            check_b("tmo.sticky", error, 1'b1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
